// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - parametrised full-duplex UART with runtime baud, parity, stop bits and break detect
//
// Purpose: serialises SoC-side payloads onto tx_pin and deserialises rx_pin
// back into payloads. One clk domain. One oversample tick is baud_div+1 clk
// cycles and one bit lasts OVERSAMPLE ticks. Runtime configuration is latched
// per frame (TX at accept, RX at start-edge detect).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   baud_div     oversample-tick divisor minus 1
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop_bits2   1 = two TX stop bits, 0 = one
//   send_request TX request, accepted while tx_busy=0
//   tx_data      TX payload, sampled on accept
//   rx_pin       asynchronous serial input
//   tx_pin       serial output, idle high
//   tx_busy      TX frame in progress
//   tx_done      one-cycle pulse on the last cycle of the final stop bit
//   rx_data      last received payload
//   data_ready   one-cycle pulse, RX frame complete
//   parity_err   parity mismatch, valid with data_ready
//   frame_err    stop bit sampled low, valid with data_ready
//   break_det    all sampled bits low including stop, valid with data_ready
module uart_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits2,
  input  logic                 send_request,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(OVERSAMPLE - 2);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            r_tx_state;
  logic [DIV_WIDTH-1:0] r_tx_div_lat;
  logic [DIV_WIDTH-1:0] r_tx_div_cnt;
  logic [TW-1:0]        r_tx_tick;
  logic [BW-1:0]        r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par_en;
  logic                 r_tx_par_bit;
  logic                 r_tx_stop2;
  logic                 r_tx_stop_idx;
  logic                 r_tx_pin;
  logic                 r_tx_busy;
  logic                 r_tx_done;

  logic w_tx_div_wrap;
  logic w_tx_bit_end;
  logic w_tx_pre_end;
  logic w_tx_last_stop;

  assign w_tx_div_wrap  = (r_tx_div_cnt == r_tx_div_lat);
  assign w_tx_bit_end   = w_tx_div_wrap && (r_tx_tick == TICK_LAST);
  // Cycle before the last cycle of a bit; tx_done is registered, so it has to
  // be set one cycle early to be high during the final cycle of the frame.
  assign w_tx_pre_end   = (r_tx_div_lat == '0) ? (r_tx_tick == TICK_PRE)
                        : ((r_tx_tick == TICK_LAST) &&
                           (r_tx_div_cnt == r_tx_div_lat - DIV_WIDTH'(1)));
  assign w_tx_last_stop = !r_tx_stop2 || r_tx_stop_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state    <= TX_IDLE;
      r_tx_div_lat  <= '0;
      r_tx_div_cnt  <= '0;
      r_tx_tick     <= '0;
      r_tx_bit      <= '0;
      r_tx_shift    <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_tx_stop_idx <= 1'b0;
      r_tx_pin      <= 1'b1;
      r_tx_busy     <= 1'b0;
      r_tx_done     <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (r_tx_state != TX_IDLE) begin
        if (w_tx_div_wrap) begin
          r_tx_div_cnt <= '0;
          r_tx_tick    <= (r_tx_tick == TICK_LAST) ? '0 : r_tx_tick + TW'(1);
        end else begin
          r_tx_div_cnt <= r_tx_div_cnt + DIV_WIDTH'(1);
        end
      end
      case (r_tx_state)
        TX_IDLE: begin
          if (send_request) begin
            r_tx_div_lat <= baud_div;
            r_tx_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            r_tx_par_bit <= (^tx_data) ^ (parity_mode == 2'b10);
            r_tx_stop2   <= stop_bits2;
            r_tx_shift   <= tx_data;
            r_tx_div_cnt <= '0;
            r_tx_tick    <= '0;
            r_tx_busy    <= 1'b1;
            r_tx_pin     <= 1'b0;
            r_tx_state   <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_pin   <= r_tx_shift[0];
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            if (r_tx_bit == BIT_LAST) begin
              r_tx_stop_idx <= 1'b0;
              if (r_tx_par_en) begin
                r_tx_pin   <= r_tx_par_bit;
                r_tx_state <= TX_PARITY;
              end else begin
                r_tx_pin   <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_pin   <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + BW'(1);
            end
          end
        end
        TX_PARITY: begin
          if (w_tx_bit_end) begin
            r_tx_pin   <= 1'b1;
            r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tx_last_stop && w_tx_pre_end) begin
            r_tx_done <= 1'b1;
          end
          if (w_tx_bit_end) begin
            if (w_tx_last_stop) begin
              r_tx_busy  <= 1'b0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_stop_idx <= 1'b1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t            r_rx_state;
  logic                 r_rx_s1;
  logic                 r_rx_s2;
  logic                 r_rx_prev;
  logic [DIV_WIDTH-1:0] r_rx_div_lat;
  logic [DIV_WIDTH-1:0] r_rx_div_cnt;
  logic [TW-1:0]        r_rx_tick;
  logic [BW-1:0]        r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_en;
  logic                 r_rx_odd;
  logic                 r_rx_par_bit;
  logic                 r_rx_ones;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_dr;
  logic                 r_rx_perr;
  logic                 r_rx_ferr;
  logic                 r_rx_brk;

  logic w_rx_div_wrap;
  logic w_rx_half;
  logic w_rx_full;
  logic w_rx_par_err;
  logic w_rx_break;

  assign w_rx_div_wrap = (r_rx_div_cnt == r_rx_div_lat);
  assign w_rx_half     = w_rx_div_wrap && (r_rx_tick == TICK_HALF);
  assign w_rx_full     = w_rx_div_wrap && (r_rx_tick == TICK_LAST);
  assign w_rx_par_err  = r_rx_par_en && (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_odd));
  assign w_rx_break    = !r_rx_s2 && !r_rx_ones;

  // Synchroniser flops reset high so a reset does not look like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx_pin;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_div_lat <= '0;
      r_rx_div_cnt <= '0;
      r_rx_tick    <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_odd     <= 1'b0;
      r_rx_par_bit <= 1'b0;
      r_rx_ones    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_dr      <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_brk     <= 1'b0;
    end else begin
      r_rx_dr <= 1'b0;
      if (r_rx_state != RX_IDLE && r_rx_state != RX_BREAK) begin
        if (w_rx_div_wrap) begin
          r_rx_div_cnt <= '0;
          r_rx_tick    <= (r_rx_tick == TICK_LAST) ? '0 : r_rx_tick + TW'(1);
        end else begin
          r_rx_div_cnt <= r_rx_div_cnt + DIV_WIDTH'(1);
        end
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_div_lat <= baud_div;
            r_rx_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            r_rx_odd     <= (parity_mode == 2'b10);
            r_rx_div_cnt <= '0;
            r_rx_tick    <= '0;
            r_rx_state   <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_half) begin
            // Restart the tick count so later samples land at mid-bit.
            r_rx_tick <= '0;
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_bit   <= '0;
              r_rx_ones  <= 1'b0;
              r_rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_full) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            r_rx_ones  <= r_rx_ones | r_rx_s2;
            if (r_rx_bit == BIT_LAST) begin
              r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + BW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (w_rx_full) begin
            r_rx_par_bit <= r_rx_s2;
            r_rx_ones    <= r_rx_ones | r_rx_s2;
            r_rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_rx_full) begin
            r_rx_dr    <= 1'b1;
            r_rx_data  <= r_rx_shift;
            r_rx_perr  <= w_rx_par_err;
            r_rx_ferr  <= !r_rx_s2;
            r_rx_brk   <= w_rx_break;
            r_rx_state <= w_rx_break ? RX_BREAK : RX_IDLE;
          end
        end
        RX_BREAK: begin
          // Hold off re-arming until the line has gone back high.
          if (r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign tx_pin     = r_tx_pin;
  assign tx_busy    = r_tx_busy;
  assign tx_done    = r_tx_done;
  assign rx_data    = r_rx_data;
  assign data_ready = r_rx_dr;
  assign parity_err = r_rx_perr;
  assign frame_err  = r_rx_ferr;
  assign break_det  = r_rx_brk;

endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - scoreboard bench for uart_cfg (8-bit and 7-bit instances)
module tb_uart_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // 8-bit instance
  logic [15:0] div8 = '0;
  logic [1:0]  pm8 = 2'b00;
  logic        st2_8 = 1'b0;
  logic        req8 = 1'b0;
  logic [7:0]  txd8 = '0;
  logic        loop8 = 1'b0;
  logic        drv8 = 1'b1;
  logic        rx8;
  logic        tx8, busy8, done8, dr8, pe8, fe8, bk8;
  logic [7:0]  rxd8;
  assign rx8 = loop8 ? tx8 : drv8;

  // 7-bit instance
  logic [15:0] div7 = '0;
  logic [1:0]  pm7 = 2'b00;
  logic        st2_7 = 1'b0;
  logic        req7 = 1'b0;
  logic [6:0]  txd7 = '0;
  logic        rx7;
  logic        tx7, busy7, done7, dr7, pe7, fe7, bk7;
  logic [6:0]  rxd7;
  assign rx7 = tx7;

  uart_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_dut8 (
    .clk(clk), .reset(reset), .baud_div(div8), .parity_mode(pm8),
    .stop_bits2(st2_8), .send_request(req8), .tx_data(txd8), .rx_pin(rx8),
    .tx_pin(tx8), .tx_busy(busy8), .tx_done(done8), .rx_data(rxd8),
    .data_ready(dr8), .parity_err(pe8), .frame_err(fe8), .break_det(bk8)
  );

  uart_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_dut7 (
    .clk(clk), .reset(reset), .baud_div(div7), .parity_mode(pm7),
    .stop_bits2(st2_7), .send_request(req7), .tx_data(txd7), .rx_pin(rx7),
    .tx_pin(tx7), .tx_busy(busy7), .tx_done(done7), .rx_data(rxd7),
    .data_ready(dr7), .parity_err(pe7), .frame_err(fe7), .break_det(bk7)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cnt8 = 0, done_cnt8 = 0, rx_cnt8 = 0;
  int rs7[4];
  int dn7[4];
  int nr7 = 0, nd7 = 0;

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.data = d; e.pe = p; e.fe = f; e.bk = b;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout after %0d cycles", name, budget);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor, 8-bit instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy8) busy_cnt8++;
        if (done8) done_cnt8++;
        if (dr8) begin
          rx_cnt8++;
          if (q8.size() == 0) begin
            check("rx8_spurious_data_ready", 32'(dr8), 32'd0);
          end else begin
            e = q8.pop_front();
            check("rx8_data", 32'(rxd8), 32'(e.data));
            check("rx8_parity_err", 32'(pe8), 32'(e.pe));
            check("rx8_frame_err", 32'(fe8), 32'(e.fe));
            check("rx8_break_det", 32'(bk8), 32'(e.bk));
          end
        end
      end
    end
  end

  // Monitor, 7-bit instance
  initial begin
    exp_t e;
    logic pbusy7;
    pbusy7 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy7 && !pbusy7 && nr7 < 4) begin rs7[nr7] = cyc; nr7++; end
        if (done7 && nd7 < 4) begin dn7[nd7] = cyc; nd7++; end
        if (dr7) begin
          if (q7.size() == 0) begin
            check("rx7_spurious_data_ready", 32'(dr7), 32'd0);
          end else begin
            e = q7.pop_front();
            check("rx7_data", 32'(rxd7), 32'(e.data));
            check("rx7_parity_err", 32'(pe7), 32'(e.pe));
            check("rx7_frame_err", 32'(fe7), 32'(e.fe));
            check("rx7_break_det", 32'(bk7), 32'(e.bk));
          end
        end
      end
      pbusy7 = busy7;
    end
  end

  task automatic send8(input logic [7:0] d);
    txd8 = d;
    req8 = 1'b1;
    tick(1);
    req8 = 1'b0;
  endtask

  task automatic wait_idle8(input string name, input int budget);
    int k = 0;
    while ((busy8 || q8.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) timeout_fail(name, budget);
  endtask

  // bits[0] goes on the line first; each bit held cpb cycles; line left at last bit.
  task automatic drive_bits(input logic [15:0] bits, input int n, input int cpb);
    for (int i = 0; i < n; i++) begin
      drv8 = bits[i];
      tick(cpb);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int done_before, rx_before;

    // Reset state
    reset = 1'b1;
    tick(3);
    check("reset_tx_pin", 32'(tx8), 32'd1);
    check("reset_tx_busy", 32'(busy8), 32'd0);
    check("reset_tx_done", 32'(done8), 32'd0);
    check("reset_data_ready", 32'(dr8), 32'd0);
    check("reset_rx_data", 32'(rxd8), 32'd0);
    check("reset_parity_err", 32'(pe8), 32'd0);
    check("reset_frame_err", 32'(fe8), 32'd0);
    check("reset_break_det", 32'(bk8), 32'd0);
    reset = 1'b0;
    tick(5);

    // Loopback 0xA5, even parity, one stop, baud_div 0: 11 bits * 16 = 176
    loop8 = 1'b1; pm8 = 2'b01; st2_8 = 1'b0; div8 = 16'd0;
    busy_cnt8 = 0; done_cnt8 = 0;
    q8.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
    send8(8'hA5);
    wait_idle8("a5_loopback", 400);
    tick(5);
    check("a5_busy_cycles", 32'(busy_cnt8), 32'd176);
    check("a5_tx_done_pulses", 32'(done_cnt8), 32'd1);

    // 7-bit, no parity, two stops, baud_div 2: 10 bits * 48 = 480 per frame
    div7 = 16'd2; pm7 = 2'b00; st2_7 = 1'b1;
    q7.push_back(mk(9'h07F, 1'b0, 1'b0, 1'b0));
    q7.push_back(mk(9'h001, 1'b0, 1'b0, 1'b0));
    txd7 = 7'h7F;
    req7 = 1'b1;
    tick(1);
    txd7 = 7'h01;
    k = 0;
    while (nr7 < 2 && k < 1500) begin tick(1); k++; end
    if (k >= 1500) timeout_fail("b2b_second_accept", 1500);
    req7 = 1'b0;
    k = 0;
    while ((busy7 || q7.size() != 0) && k < 1500) begin tick(1); k++; end
    if (k >= 1500) timeout_fail("b2b_finish", 1500);
    tick(5);
    check("b2b_accepts", 32'(nr7), 32'd2);
    check("b2b_tx_done_pulses", 32'(nd7), 32'd2);
    check("b2b_frame1_len", 32'(dn7[0] - rs7[0] + 1), 32'd480);
    check("b2b_accept_gap", 32'(rs7[1] - dn7[0]), 32'd2);
    check("b2b_frame2_len", 32'(dn7[1] - rs7[1] + 1), 32'd480);

    // Odd parity, 0x3C has even weight so correct parity bit is 1; send 0
    loop8 = 1'b0; drv8 = 1'b1; pm8 = 2'b10;
    tick(20);
    q8.push_back(mk(9'h03C, 1'b1, 1'b0, 1'b0));
    drive_bits({1'b1, 1'b0, 8'h3C, 1'b0}, 11, 16);
    drv8 = 1'b1;
    tick(32);
    check("odd_parity_frame_consumed", 32'(q8.size()), 32'd0);

    // 0x55 with stop bit low, no parity
    pm8 = 2'b00;
    q8.push_back(mk(9'h055, 1'b0, 1'b1, 1'b0));
    drive_bits({1'b0, 8'h55, 1'b0}, 10, 16);
    drv8 = 1'b1;
    tick(32);
    check("frame_err_frame_consumed", 32'(q8.size()), 32'd0);

    // Break: all zeros including stop, line held low a while afterwards
    rx_before = rx_cnt8;
    q8.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
    drive_bits({1'b0, 8'h00, 1'b0}, 10, 16);
    tick(200);
    drv8 = 1'b1;
    tick(40);
    check("break_single_data_ready", 32'(rx_cnt8 - rx_before), 32'd1);

    // 3-cycle low glitch is a false start
    rx_before = rx_cnt8;
    drv8 = 1'b0;
    tick(3);
    drv8 = 1'b1;
    tick(60);
    check("glitch_no_data_ready", 32'(rx_cnt8 - rx_before), 32'd0);
    q8.push_back(mk(9'h00F, 1'b0, 1'b0, 1'b0));
    drive_bits({1'b1, 8'h0F, 1'b0}, 10, 16);
    drv8 = 1'b1;
    tick(32);
    check("post_glitch_frame_consumed", 32'(q8.size()), 32'd0);

    // Reset during data bit 4 of a loopback TX frame
    loop8 = 1'b1; pm8 = 2'b01;
    send8(8'h5A);
    tick(16 + 4 * 16 + 8 - 1);
    done_before = done_cnt8;
    rx_before = rx_cnt8;
    reset = 1'b1;
    #1;
    check("midreset_tx_pin", 32'(tx8), 32'd1);
    check("midreset_tx_busy", 32'(busy8), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(200);
    check("midreset_no_tx_done", 32'(done_cnt8 - done_before), 32'd0);
    check("midreset_no_data_ready", 32'(rx_cnt8 - rx_before), 32'd0);
    q8.push_back(mk(9'h081, 1'b0, 1'b0, 1'b0));
    send8(8'h81);
    wait_idle8("post_reset_0x81", 400);
    tick(5);
    check("post_reset_queue_empty", 32'(q8.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
